multiplier_pipe_field: RTL and testbench

- Parametrised, fully pipelined unsigned MUL_SIZE x MUL_SIZE multiplier built from DSP-sized partial-product tiles.
- Successor to the fixed 56-bit upper/middle multipliers used by the modular-reduction datapath. Accepts a new operand pair every cycle and carries a tag through the pipeline.
- Selects at run time which field of the 2*MUL_SIZE product is returned: low, middle or upper-2.
- Supports valid/ready backpressure so it can sit between FIFOs in the reduction pipeline.

---
 rtl/multiplier_pipe_field.sv | 169 ++++++++++++++++
 tb/tb_multiplier_pipe_field.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/multiplier_pipe_field.sv
// Purpose: pipelined unsigned MUL_SIZE x MUL_SIZE multiplier built from tiles; returns the low, middle or upper-2 field of the product.
// Latency: 3 cycles from input handshake to out_valid; accepts one operand pair per cycle.
// Backpressure: all stages stall together while out_valid & ~out_ready; in_ready = ~out_valid | out_ready.
//
// Ports:
//   clk, rst             clock, synchronous active-high reset
//   in_valid/in_ready    operand handshake; a, b, mode and in_tag are captured together
//   out_valid/out_ready  result handshake; res is the selected field, zero-extended
//   out_tag, out_mode    sideband values that travelled with this result
module multiplier_pipe_field #(
    parameter int MUL_SIZE = 56,
    parameter int RADIX    = 54,
    parameter int TILE     = 18,
    parameter int TAG_W    = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [MUL_SIZE-1:0] a,
    input  logic [MUL_SIZE-1:0] b,
    input  logic [1:0]          mode,
    input  logic [TAG_W-1:0]    in_tag,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [RADIX-1:0]    res,
    output logic [TAG_W-1:0]    out_tag,
    output logic [1:0]          out_mode
);

    localparam int NT   = (MUL_SIZE + TILE - 1) / TILE;
    localparam int TOPW = MUL_SIZE - (NT - 1) * TILE;
    localparam int WMAX = (TILE > TOPW) ? TILE : TOPW;
    localparam int PPW  = 2 * WMAX;
    localparam int PW   = 2 * MUL_SIZE;

    // The upper-2 field reads P[2*RADIX+3:2*RADIX+2], so it has to fit inside the product.
    generate
        if (RADIX > MUL_SIZE - 2 || TILE < 2) begin : g_bad_params
            $error("multiplier_pipe_field: need RADIX <= MUL_SIZE-2 and TILE >= 2");
        end
    endgenerate

    // Mask for tile i: the top tile holds whatever bits remain above (NT-1)*TILE.
    function automatic logic [WMAX-1:0] tile_mask(input int i);
        int w;
        w = (i == NT - 1) ? TOPW : TILE;
        return {WMAX{1'b1}} >> (WMAX - w);
    endfunction

    logic adv;
    assign adv      = ~out_valid | out_ready;
    assign in_ready = adv;

    // Operand tiles
    logic [WMAX-1:0] a_t [NT];
    logic [WMAX-1:0] b_t [NT];

    always_comb begin
        for (int i = 0; i < NT; i++) begin
            a_t[i] = WMAX'(a >> (i * TILE)) & tile_mask(i);
            b_t[i] = WMAX'(b >> (i * TILE)) & tile_mask(i);
        end
    end

    // S1: tile partial products
    logic [PPW-1:0]   p_q [NT][NT];
    logic             v1_q, v2_q, v3_q;
    logic [1:0]       m1_q, m2_q, m3_q;
    logic [TAG_W-1:0] t1_q, t2_q, t3_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            v1_q <= 1'b0;
            m1_q <= '0;
            t1_q <= '0;
            for (int i = 0; i < NT; i++) begin
                for (int j = 0; j < NT; j++) begin
                    p_q[i][j] <= '0;
                end
            end
        end else if (adv) begin
            v1_q <= in_valid;
            m1_q <= mode;
            t1_q <= in_tag;
            for (int i = 0; i < NT; i++) begin
                for (int j = 0; j < NT; j++) begin
                    p_q[i][j] <= PPW'(a_t[i]) * PPW'(b_t[j]);
                end
            end
        end
    end

    // S2: one full-width sum per multiplicand tile
    logic [PW-1:0] row_d [NT];
    logic [PW-1:0] row_q [NT];

    always_comb begin
        for (int i = 0; i < NT; i++) begin
            row_d[i] = '0;
            for (int j = 0; j < NT; j++) begin
                row_d[i] = row_d[i] + (PW'(p_q[i][j]) << (j * TILE));
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            v2_q <= 1'b0;
            m2_q <= '0;
            t2_q <= '0;
            for (int i = 0; i < NT; i++) begin
                row_q[i] <= '0;
            end
        end else if (adv) begin
            v2_q <= v1_q;
            m2_q <= m1_q;
            t2_q <= t1_q;
            for (int i = 0; i < NT; i++) begin
                row_q[i] <= row_d[i];
            end
        end
    end

    // S3: full product
    logic [PW-1:0] prod_d;
    logic [PW-1:0] prod_q;

    always_comb begin
        prod_d = '0;
        for (int i = 0; i < NT; i++) begin
            prod_d = prod_d + (row_q[i] << (i * TILE));
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            v3_q   <= 1'b0;
            m3_q   <= '0;
            t3_q   <= '0;
            prod_q <= '0;
        end else if (adv) begin
            v3_q   <= v2_q;
            m3_q   <= m2_q;
            t3_q   <= t2_q;
            prod_q <= prod_d;
        end
    end

    // Field select straight off the S3 register, so res is stable while stalled.
    always_comb begin
        res = '0;
        case (m3_q)
            2'd0:    res = prod_q[RADIX-1:0];
            2'd1:    res = prod_q[RADIX +: RADIX];
            2'd2:    res = RADIX'(prod_q[2*RADIX+2 +: 2]);
            default: res = '0;
        endcase
    end

    // Some product bits never reach any field; collect them so they read as intentionally unused.
    logic prod_unused;
    assign prod_unused = ^prod_q;

    assign out_valid = v3_q;
    assign out_tag   = t3_q;
    assign out_mode  = m3_q;

endmodule

// File: tb/tb_multiplier_pipe_field.sv
module tb_multiplier_pipe_field;

    localparam int MS = 56;
    localparam int RX = 54;
    localparam int TW = 4;

    logic          clk = 1'b0;
    logic          rst, in_valid, in_ready, out_valid, out_ready;
    logic [MS-1:0] a, b;
    logic [1:0]    mode, out_mode;
    logic [TW-1:0] in_tag, out_tag;
    logic [RX-1:0] res;

    always #5 clk = ~clk;

    multiplier_pipe_field #(.MUL_SIZE(MS), .RADIX(RX), .TILE(18), .TAG_W(TW)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .mode(mode), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready),
        .res(res), .out_tag(out_tag), .out_mode(out_mode)
    );

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [RX-1:0] res;
        logic [TW-1:0] tag;
        logic [1:0]    mode;
        int            cyc;
        bit            lat;
    } exp_t;

    exp_t          q[$];
    logic [RX-1:0] cur_lit = '0;
    bit            cur_use_lit = 1'b0;
    bit            cur_lat = 1'b0;
    bit            rand_bp = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: actual %0h required %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Reference: full product by plain arithmetic, fields extracted by division/modulo.
    function automatic logic [RX-1:0] model(input logic [MS-1:0] x, input logic [MS-1:0] y,
                                             input logic [1:0] m);
        logic [2*MS-1:0] p, base;
        p    = {{MS{1'b0}}, x} * {{MS{1'b0}}, y};
        base = (2*MS)'(1) << RX;
        case (m)
            2'd0:    return RX'(p % base);
            2'd1:    return RX'((p / base) % base);
            2'd2:    return RX'((p / (base * base * 4)) % 4);
            default: return '0;
        endcase
    endfunction

    function automatic logic [MS-1:0] rnd();
        logic [63:0] r;
        r = {$urandom(), $urandom()};
        if ($urandom_range(0, 7) == 0) r = '1;
        return MS'(r);
    endfunction

    // Monitor / scoreboard
    bit            prev_stall = 1'b0;
    logic [RX-1:0] held_res;
    logic [TW-1:0] held_tag;
    logic [1:0]    held_mode;
    exp_t          e;

    always @(negedge clk) begin
        if (rst) begin
            q.delete();
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                chk("stall_valid", 64'(out_valid), 64'd1);
                chk("stall_res",   64'(res),      64'(held_res));
                chk("stall_tag",   64'(out_tag),  64'(held_tag));
                chk("stall_mode",  64'(out_mode), 64'(held_mode));
            end
            prev_stall = 1'b0;
            if (out_valid) begin
                if (!out_ready) begin
                    chk("in_ready_stall", 64'(in_ready), 64'd0);
                    prev_stall = 1'b1;
                    held_res   = res;
                    held_tag   = out_tag;
                    held_mode  = out_mode;
                end else if (q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_out: actual tag %0h res %0h required no output (t=%0t)",
                             out_tag, res, $time);
                end else begin
                    e = q.pop_front();
                    chk("res",  64'(res),      64'(e.res));
                    chk("tag",  64'(out_tag),  64'(e.tag));
                    chk("mode", 64'(out_mode), 64'(e.mode));
                    if (e.lat) chk("latency", 64'(cyc - e.cyc), 64'd3);
                end
            end
            if (in_valid && in_ready) begin
                e.res  = cur_use_lit ? cur_lit : model(a, b, mode);
                e.tag  = in_tag;
                e.mode = mode;
                e.cyc  = cyc;
                e.lat  = cur_lat;
                q.push_back(e);
            end
        end
    end

    // Drive one operand pair and hold it until accepted (called at posedge+1).
    task automatic issue(input logic [MS-1:0] ia, input logic [MS-1:0] ib, input logic [1:0] im,
                         input logic [TW-1:0] it, input bit use_lit, input logic [RX-1:0] lit,
                         input bit lat);
        bit acc;
        int n;
        acc = 1'b0;
        n   = 0;
        a = ia; b = ib; mode = im; in_tag = it; in_valid = 1'b1;
        cur_use_lit = use_lit; cur_lit = lit; cur_lat = lat;
        while (!acc && n < 100) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
            n++;
        end
        if (!acc) begin
            tests++;
            fails++;
            $display("FAIL issue_timeout: actual in_ready 0 for %0d cycles required 1 (tag %0h)", n, it);
        end
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        cur_lat  = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    logic [MS-1:0] ones;

    initial begin
        ones = '1;
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        a = '0; b = '0; mode = '0; in_tag = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_res",       64'(res),       64'd0);
        chk("rst_out_tag",   64'(out_tag),   64'd0);
        chk("rst_out_mode",  64'(out_mode),  64'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("in_ready_after_rst", 64'(in_ready), 64'd1);

        // Directed field checks, back to back, exact latency
        issue(56'd3, 56'd5, 2'd0, 4'h1, 1'b1, 54'd15, 1'b1);
        issue(56'd3, 56'd5, 2'd1, 4'h2, 1'b1, 54'd0,  1'b1);
        issue(56'd3, 56'd5, 2'd2, 4'h3, 1'b1, 54'd0,  1'b1);
        issue(56'd3, 56'd5, 2'd3, 4'h4, 1'b1, 54'd0,  1'b1);
        issue(ones, ones, 2'd0, 4'h5, 1'b1, 54'd1, 1'b1);
        issue(ones, ones, 2'd1, 4'h6, 1'b1, 54'h3FFFFFFFFFFFF8, 1'b1);
        issue(ones, ones, 2'd2, 4'h7, 1'b1, 54'd3, 1'b1);
        issue(ones, ones, 2'd3, 4'h8, 1'b1, 54'd0, 1'b1);
        issue(56'd1 << 54, 56'd1, 2'd1, 4'h9, 1'b1, 54'd1, 1'b1);
        issue(56'd1 << 55, 56'd1 << 55, 2'd2, 4'hA, 1'b1, 54'd1, 1'b1);
        issue(56'd1 << 55, 56'd1 << 55, 2'd1, 4'hB, 1'b1, 54'd0, 1'b1);
        idle(6);

        // Back-to-back random stream, tags 0..7
        for (int t = 0; t < 8; t++)
            issue(rnd(), rnd(), 2'($urandom_range(0, 2)), TW'(t), 1'b0, '0, 1'b1);
        idle(6);

        // Stall: out_ready low for 5 cycles once the first result is presented
        out_ready = 1'b0;
        fork
            begin
                for (int t = 0; t < 4; t++)
                    issue(rnd(), rnd(), 2'($urandom_range(0, 2)), TW'(12 + t), 1'b0, '0, 1'b0);
                in_valid = 1'b0;
            end
            begin
                int k;
                k = 0;
                while (!out_valid && k < 50) begin
                    @(posedge clk);
                    #1;
                    k++;
                end
                repeat (5) @(posedge clk);
                #1;
                out_ready = 1'b1;
            end
        join
        idle(8);

        // Reset with two operations in flight
        issue(rnd(), rnd(), 2'd0, 4'h1, 1'b0, '0, 1'b0);
        issue(rnd(), rnd(), 2'd1, 4'h2, 1'b0, '0, 1'b0);
        in_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("post_rst_out_valid", 64'(out_valid), 64'd0);
            if (k == 0) chk("post_rst_in_ready", 64'(in_ready), 64'd1);
        end
        @(posedge clk);
        #1;
        issue(rnd(), rnd(), 2'($urandom_range(0, 2)), 4'h3, 1'b0, '0, 1'b1);
        idle(6);

        // Random bubbles and random backpressure
        rand_bp = 1'b1;
        fork
            while (rand_bp) begin
                @(posedge clk);
                #1;
                if (rand_bp) out_ready = ($urandom_range(0, 3) != 0);
            end
        join_none
        for (int n = 0; n < 30; n++) begin
            if ($urandom_range(0, 3) == 0) idle(1);
            issue(rnd(), rnd(), 2'($urandom_range(0, 3)), TW'(n), 1'b0, '0, 1'b0);
        end
        in_valid = 1'b0;
        rand_bp  = 1'b0;
        @(posedge clk);
        #2;
        out_ready = 1'b1;

        begin
            int k;
            k = 0;
            while (q.size() != 0 && k < 200) begin
                @(posedge clk);
                k++;
            end
        end
        idle(2);
        chk("drain_empty", 64'(q.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: actual simulation still running required finished");
        fails++;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $fatal(1, "watchdog");
    end

endmodule
